aes_req_scheduler: RTL
======================

Name: aes_req_scheduler

Overview:
- Front-end controller that shares the 12-lane AES-128 cipher pipe between NUM_REQ independent requesters.
- Performs round-robin arbitration and issues at most one block per cycle into the pipe.
- Tags each issued block with its requester ID and returns results in issue order through a buffered valid/ready response port.
- Owns the pipe key: on a key-update request it sequences drain → key load → resume, so no block is ever encrypted under a mixed key. The pipe has no backpressure, so issue is credit-limited by output buffer space.

Parameters:
- NUM_REQ, 4, number of requesters.
- ID_W, 2, requester ID width; must be ≥ clog2(NUM_REQ).
- OBUF_DEPTH, 32, output buffer and tag FIFO depth; equals the maximum number of outstanding blocks.
- CNT_W, 6, outstanding counter width; must be ≥ clog2(OBUF_DEPTH+1).

Ports:
- clk  in  1  clock
- rst  in  1  reset
- req_valid  in  NUM_REQ  per-requester block valid
- req_ready  out  NUM_REQ  per-requester accept (one-hot or zero)
- req_data  in  NUM_REQ*128  plaintext; requester i occupies bits [128*i+127:128*i]
- cfg_key_valid  in  1  key update request; held until cfg_key_ready
- cfg_key  in  128  new key
- cfg_key_ready  out  1  one-cycle key-accepted pulse
- pipe_key  out  128  key driven to the cipher pipe
- pipe_in_valid  out  1  block issue to the pipe (data_in_valid)
- pipe_in_data  out  128  block to the pipe
- pipe_out_valid  in  1  pipe result valid
- pipe_out_data  in  128  pipe result
- resp_valid  out  1  result available
- resp_ready  in  1  downstream accept
- resp_data  out  128  ciphertext
- resp_id  out  ID_W  originating requester
- outstanding  out  CNT_W  blocks issued but not yet popped from resp
- err  out  1  sticky protocol error

Behaviour:
- Reset: rst is synchronous, active-high; clock clk. All outputs reset to 0, including pipe_key. FSM=RUN, rr pointer=0, tag FIFO and output FIFO empty, outstanding=0. Reset mid-operation discards all in-flight and buffered blocks. The pipe shares the same rst. pipe_out_valid is ignored while rst=1.
- FSM states:
  - RUN: issue allowed. If cfg_key_valid=1, go to DRAIN; the grant in that same cycle is suppressed.
  - DRAIN: req_ready=0. Remain until the tag FIFO is empty (pipe holds 0 blocks), then go to KEYLOAD. Responses keep draining during DRAIN.
  - KEYLOAD: exactly one cycle. pipe_key<=cfg_key, cfg_key_ready=1, then go to RUN.
- Arbitration:
  - Grant is combinational from req_valid.
  - Grant is allowed only in RUN, with cfg_key_valid=0 and outstanding<OBUF_DEPTH (registered count).
  - Search starts at the rr pointer and wraps mod NUM_REQ. The first valid requester i gets req_ready[i]=1.
  - After a grant to i, the pointer becomes (i+1) mod NUM_REQ. Without a grant, the pointer holds.
- Issue: a handshake in cycle T produces pipe_in_valid=1 and pipe_in_data=req_data[i] in cycle T+1, both registered. The tag FIFO pushes i in cycle T.
- Return:
  - pipe_out_valid pops the tag FIFO and pushes {tag, pipe_out_data} into the output FIFO.
  - resp_valid rises the next cycle. The output FIFO is first-word-fall-through on resp_*.
  - Results return strictly in issue order.
- outstanding: +1 on req handshake, −1 on resp handshake, unchanged when both occur in the same cycle. The value is never allowed to exceed OBUF_DEPTH.
- err is set and held until rst on either event:
  - pipe_out_valid with the tag FIFO empty: data is dropped.
  - output FIFO push while full: data is dropped.
- Throughput: one block per cycle sustained while resp_ready=1 and no key update is in progress.

Test Plan:
1. Key load cfg_key=000102030405060708090a0b0c0d0e0f, then req_data[0]=00112233445566778899aabbccddeeff → cfg_key_ready pulses exactly one cycle; resp_id=0, resp_data=69c4e0d86a7b0430d8cdb78070b4c55a.
2. All 4 req_valid held high with resp_ready=1 → grants 0,1,2,3,0,1,… one per cycle; resp_id sequence matches; pipe_in_valid continuous.
3. resp_ready=0 with continuous requests → exactly 32 accepted, then req_ready=0 and outstanding=32; one resp pop → exactly one more accepted.
4. Key change requested with 10 blocks in flight → no grants until tag FIFO empty; those 10 results are encrypted under the old key; after the cfg_key_ready pulse, new blocks are encrypted under the new key.
5. outstanding=31, req handshake and resp handshake in the same cycle → outstanding stays 31; err remains 0.
6. rst asserted mid-stream with 20 outstanding → next cycle all outputs 0, outstanding=0; first post-reset request from req 3 only → granted, resp_id=3.

Source files
------------

// File: rtl/aes_req_scheduler.sv
// Round-robin front end for a shared 12-lane AES-128 pipe: tags issued blocks,
// returns results in order through a FWFT buffer, and sequences key changes.
module aes_req_scheduler #(
    parameter int NUM_REQ    = 4,
    parameter int ID_W       = 2,
    parameter int OBUF_DEPTH = 32,
    parameter int CNT_W      = 6
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [NUM_REQ*128-1:0] req_data,
    input  logic                   cfg_key_valid,
    input  logic [127:0]           cfg_key,
    output logic                   cfg_key_ready,
    output logic [127:0]           pipe_key,
    output logic                   pipe_in_valid,
    output logic [127:0]           pipe_in_data,
    input  logic                   pipe_out_valid,
    input  logic [127:0]           pipe_out_data,
    output logic                   resp_valid,
    input  logic                   resp_ready,
    output logic [127:0]           resp_data,
    output logic [ID_W-1:0]        resp_id,
    output logic [CNT_W-1:0]       outstanding,
    output logic                   err
);

    localparam int              AW       = (OBUF_DEPTH > 1) ? $clog2(OBUF_DEPTH) : 1;
    localparam logic [AW:0]     DEPTH_C  = (AW+1)'(OBUF_DEPTH);
    localparam logic [AW-1:0]   LAST_PTR = AW'(OBUF_DEPTH - 1);

    typedef enum logic [1:0] {RUN, DRAIN, KEYLOAD} state_t;

    function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    state_t          state, state_nxt;
    logic            in_run, key_load;
    logic            grant_en, handshake, found;
    logic [ID_W-1:0] grant_id, rr_ptr, arb_idx;

    logic [ID_W-1:0] tag_mem [OBUF_DEPTH];
    logic [AW-1:0]   tag_wr, tag_rd;
    logic [AW:0]     tag_cnt;
    logic            tag_empty, tag_push, tag_pop;

    logic [ID_W+127:0] ob_mem [OBUF_DEPTH];
    logic [AW-1:0]     ob_wr, ob_rd;
    logic [AW:0]       ob_cnt;
    logic              ob_full, ob_push, ob_pop;

    always_ff @(posedge clk) begin
        if (rst) state <= RUN;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            RUN:     if (cfg_key_valid) state_nxt = DRAIN;
            DRAIN:   if (tag_empty)     state_nxt = KEYLOAD;
            KEYLOAD: state_nxt = RUN;
            default: state_nxt = RUN;
        endcase
    end

    always_comb begin
        in_run        = (state == RUN);
        key_load      = (state == KEYLOAD);
        cfg_key_ready = key_load;
    end

    // Issue is credit-limited: the pipe cannot stall, so every block in flight
    // must already own a slot in the output buffer.
    assign grant_en = !rst && in_run && !cfg_key_valid
                      && (outstanding < CNT_W'(OBUF_DEPTH));

    always_comb begin
        req_ready = '0;
        grant_id  = '0;
        found     = 1'b0;
        arb_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            arb_idx = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
            if (grant_en && !found && req_valid[arb_idx]) begin
                found              = 1'b1;
                req_ready[arb_idx] = 1'b1;
                grant_id           = arb_idx;
            end
        end
    end

    assign handshake = |req_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr        <= '0;
            pipe_in_valid <= 1'b0;
            pipe_in_data  <= '0;
            pipe_key      <= '0;
        end else begin
            pipe_in_valid <= handshake;
            if (handshake) begin
                rr_ptr       <= (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
                pipe_in_data <= req_data[128*grant_id +: 128];
            end
            if (key_load) pipe_key <= cfg_key;
        end
    end

    assign tag_empty = (tag_cnt == '0);
    assign tag_push  = handshake && (tag_cnt != DEPTH_C);
    assign tag_pop   = pipe_out_valid && !tag_empty;
    assign ob_full   = (ob_cnt == DEPTH_C);
    assign ob_push   = tag_pop && !ob_full;
    assign ob_pop    = resp_valid && resp_ready;

    always_ff @(posedge clk) begin
        if (tag_push) tag_mem[tag_wr] <= grant_id;
        if (ob_push)  ob_mem[ob_wr]   <= {tag_mem[tag_rd], pipe_out_data};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tag_wr      <= '0;
            tag_rd      <= '0;
            tag_cnt     <= '0;
            ob_wr       <= '0;
            ob_rd       <= '0;
            ob_cnt      <= '0;
            outstanding <= '0;
            err         <= 1'b0;
        end else begin
            if (tag_push) tag_wr <= next_ptr(tag_wr);
            if (tag_pop)  tag_rd <= next_ptr(tag_rd);
            if (tag_push && !tag_pop)      tag_cnt <= tag_cnt + 1'b1;
            else if (!tag_push && tag_pop) tag_cnt <= tag_cnt - 1'b1;

            if (ob_push) ob_wr <= next_ptr(ob_wr);
            if (ob_pop)  ob_rd <= next_ptr(ob_rd);
            if (ob_push && !ob_pop)      ob_cnt <= ob_cnt + 1'b1;
            else if (!ob_push && ob_pop) ob_cnt <= ob_cnt - 1'b1;

            if (handshake && !ob_pop)      outstanding <= outstanding + 1'b1;
            else if (!handshake && ob_pop) outstanding <= outstanding - 1'b1;

            // Orphan results and buffer overflow both lose data permanently.
            if ((pipe_out_valid && tag_empty) || (tag_pop && ob_full)) err <= 1'b1;
        end
    end

    always_comb begin
        resp_valid          = (ob_cnt != '0);
        {resp_id, resp_data} = resp_valid ? ob_mem[ob_rd] : '0;
    end

endmodule
